// File: rtl/gyro_integrator_if.sv
// rtl/gyro_integrator_if.sv - sample/recenter inputs and angle outputs of the gyro integrator
interface gyro_integrator_if;
    logic               sample_valid_in;
    logic signed [15:0] gx_in;
    logic signed [15:0] gy_in;
    logic signed [15:0] gz_in;
    logic               recenter_in;
    logic [8:0]         pitch_out;
    logic [8:0]         roll_out;
    logic [8:0]         yaw_out;
    logic               angles_valid_out;
    logic               busy_out;
    logic [7:0]         overrun_out;

    // Design side: consumes rates and recenter, produces angles and status.
    modport slave (
        input  sample_valid_in,
        input  gx_in,
        input  gy_in,
        input  gz_in,
        input  recenter_in,
        output pitch_out,
        output roll_out,
        output yaw_out,
        output angles_valid_out,
        output busy_out,
        output overrun_out
    );

    // Source side: supplies rates and recenter, observes angles and status.
    modport master (
        output sample_valid_in,
        output gx_in,
        output gy_in,
        output gz_in,
        output recenter_in,
        input  pitch_out,
        input  roll_out,
        input  yaw_out,
        input  angles_valid_out,
        input  busy_out,
        input  overrun_out
    );
endinterface

// File: rtl/gyro_integrator.sv
// rtl/gyro_integrator.sv - three-axis gyro rate integrator with wrapped degree outputs (option: GYRO_DEADBAND_EN)
module gyro_integrator #(
    parameter int SHIFT    = 0,
    parameter int DEADBAND = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    gyro_integrator_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC_X = 3'd1,
        ACC_Y = 3'd2,
        ACC_Z = 3'd3,
        DONE  = 3'd4
    } state_t;

    // One full turn in 1/256 degree units.
    localparam logic signed [18:0] TURN = 19'sd92160;

    state_t      state;
    logic [15:0] rate_x;
    logic [15:0] rate_y;
    logic [15:0] rate_z;
    logic [16:0] acc_x;
    logic [16:0] acc_y;
    logic [16:0] acc_z;
    logic [8:0]  pitch_q;
    logic [8:0]  roll_q;
    logic [8:0]  yaw_q;
    logic        valid_q;
    logic        busy_q;
    logic [7:0]  overrun_q;

    logic [15:0]        sel_rate;
    logic [16:0]        sel_acc;
    logic signed [15:0] rate_shift;
    logic signed [17:0] delta;
    logic signed [18:0] sum;
    logic signed [18:0] wrapped;
    logic [16:0]        acc_next;

`ifdef GYRO_DEADBAND_EN
    localparam logic [17:0] DB_LIMIT = 18'(DEADBAND);
    logic [17:0] delta_mag;
`endif

    // Shared adder: pick the axis for the current state, scale, optionally deadband, add and wrap once.
    always_comb begin
        sel_rate   = rate_x;
        sel_acc    = acc_x;
        case (state)
            ACC_Y:   begin sel_rate = rate_y; sel_acc = acc_y; end
            ACC_Z:   begin sel_rate = rate_z; sel_acc = acc_z; end
            default: begin sel_rate = rate_x; sel_acc = acc_x; end
        endcase
        rate_shift = $signed(sel_rate) >>> SHIFT;
        delta      = {{2{rate_shift[15]}}, rate_shift};
`ifdef GYRO_DEADBAND_EN
        delta_mag  = delta[17] ? 18'(-delta) : 18'(delta);
        if (delta_mag < DB_LIMIT) begin
            delta = 18'sd0;
        end
`endif
        sum = $signed({2'b00, sel_acc}) + $signed({delta[17], delta});
        // |delta| never exceeds half a turn, so one correction lands back in range.
        if (sum >= TURN) begin
            wrapped = sum - TURN;
        end else if (sum < 19'sd0) begin
            wrapped = sum + TURN;
        end else begin
            wrapped = sum;
        end
        acc_next = wrapped[16:0];
    end

    // Sequencer: accept in IDLE, one axis per cycle, publish angles on entry to DONE; recenter overrides everything.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state   <= IDLE;
            rate_x  <= '0;
            rate_y  <= '0;
            rate_z  <= '0;
            acc_x   <= '0;
            acc_y   <= '0;
            acc_z   <= '0;
            pitch_q <= '0;
            roll_q  <= '0;
            yaw_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.recenter_in) begin
                state   <= IDLE;
                busy_q  <= 1'b0;
                acc_x   <= '0;
                acc_y   <= '0;
                acc_z   <= '0;
                pitch_q <= '0;
                roll_q  <= '0;
                yaw_q   <= '0;
                valid_q <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.sample_valid_in) begin
                            rate_x <= bus.gx_in;
                            rate_y <= bus.gy_in;
                            rate_z <= bus.gz_in;
                            state  <= ACC_X;
                            busy_q <= 1'b1;
                        end
                    end
                    ACC_X: begin
                        acc_x <= acc_next;
                        state <= ACC_Y;
                    end
                    ACC_Y: begin
                        acc_y <= acc_next;
                        state <= ACC_Z;
                    end
                    ACC_Z: begin
                        // Angles are registered here so they and the valid pulse are visible during DONE.
                        acc_z   <= acc_next;
                        pitch_q <= acc_x[16:8];
                        roll_q  <= acc_y[16:8];
                        yaw_q   <= acc_next[16:8];
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Count strobes that arrive while a sequence is running; a recenter swallows the strobe uncounted.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            overrun_q <= '0;
        end else if (bus.sample_valid_in && !bus.recenter_in && (state != IDLE) && (overrun_q != 8'hFF)) begin
            overrun_q <= overrun_q + 8'd1;
        end
    end

    assign bus.pitch_out        = pitch_q;
    assign bus.roll_out         = roll_q;
    assign bus.yaw_out          = yaw_q;
    assign bus.angles_valid_out = valid_q;
    assign bus.busy_out         = busy_q;
    assign bus.overrun_out      = overrun_q;

endmodule
